// File: rtl/iob_iob2wishbone.sv
// IOb slave to classic Wishbone master bridge.
// One registered Wishbone cycle per IOb request, optional timeout abort.
module iob_iob2wishbone #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                error_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W/8-1:0] wb_select_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  input  logic                wb_error_i
);

  localparam int SW = DATA_W / 8;
  localparam int CW = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       cnt_inc;
  logic                timeout;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Abort once the counter would reach its all-ones value.
  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = (TIMEOUT_W > 0) && (&cnt_inc);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    ready_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid_i) begin
          addr_d  = address_i;
          wdata_d = wdata_i;
          we_d    = |wstrb_i;
          sel_d   = (|wstrb_i) ? wstrb_i : '1;
          cyc_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (wb_error_i || timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          state_d = RESP;
        end else if (wb_ack_i) begin
          rdata_d = we_q ? '0 : wb_data_i;
          err_d   = 1'b0;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rdata_o     = rdata_q;
  assign ready_o     = ready_q;
  assign error_o     = err_q;
  assign wb_addr_o   = addr_q;
  assign wb_select_o = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_data_o   = wdata_q;

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// Bench for iob_iob2wishbone: transaction model with expected-response queue.
// Randomised traffic plus literal directed cases, TIMEOUT_W=4.
module tb_iob_iob2wishbone;

  localparam int TW  = 4;
  localparam int MAXW = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        arst_i;
  logic        valid_i;
  logic [31:0] address_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        error_o;
  logic [31:0] wb_addr_o;
  logic [3:0]  wb_select_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_error_i;

  int checks = 0;
  int failures = 0;
  int rdy_cnt = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  iob_iob2wishbone #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(TW)
  ) dut (
    .clk_i(clk), .arst_i(arst_i),
    .valid_i(valid_i), .address_i(address_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .rdata_o(rdata_o), .ready_o(ready_o),
    .error_o(error_o),
    .wb_addr_o(wb_addr_o), .wb_select_o(wb_select_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
    .wb_error_i(wb_error_i)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Response checker: each ready_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!arst_i) begin
      chk("cyc_eq_stb", {31'd0, wb_cyc_o}, {31'd0, wb_stb_o});
      if (ready_o) begin
        rdy_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready actual=1 expected=0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rdata_o, e.rd);
          chk("rsp_error", {31'd0, error_o}, {31'd0, e.er});
        end
      end
    end
  end

  // mode: 0 ack, 1 error, 2 ack+error, 3 silent slave
  task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int d,
                     input int mode, input logic [31:0] rd);
    int n;
    bit to;
    logic ee;
    logic [31:0] er;
    logic [3:0] es;
    exp_t e;
    @(negedge clk);
    chk("pre_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("pre_ready", {31'd0, ready_o}, 32'd0);
    valid_i   = 1'b1;
    address_i = a;
    wdata_i   = wd;
    wstrb_i   = st;
    to = (mode == 3) || (d + 1 > MAXW);
    n  = to ? MAXW : d + 1;
    ee = to || (mode == 1) || (mode == 2);
    er = (ee || st != 4'd0) ? 32'd0 : rd;
    es = (st != 4'd0) ? st : 4'hF;
    e.rd = er;
    e.er = ee;
    exp_q.push_back(e);
    exp_cnt++;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("busy_stb", {31'd0, wb_stb_o}, 32'd1);
      chk("busy_ready", {31'd0, ready_o}, 32'd0);
      chk("busy_addr", wb_addr_o, a);
      chk("busy_data", wb_data_o, wd);
      chk("busy_sel", {28'd0, wb_select_o}, {28'd0, es});
      chk("busy_we", {31'd0, wb_we_o}, {31'd0, st != 4'd0});
      address_i = $urandom;
      wdata_i   = $urandom;
      wstrb_i   = 4'($urandom);
      wb_data_i = $urandom;
      if (i == n && !to) begin
        wb_ack_i   = (mode != 1);
        wb_error_i = (mode != 0);
        wb_data_i  = rd;
      end else begin
        wb_ack_i   = 1'b0;
        wb_error_i = 1'b0;
      end
    end
    @(negedge clk);
    wb_ack_i   = 1'b0;
    wb_error_i = 1'b0;
    wb_data_i  = $urandom;
    chk("resp_ready", {31'd0, ready_o}, 32'd1);
    chk("resp_stb", {31'd0, wb_stb_o}, 32'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    chk("idle_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("idle_ready", {31'd0, ready_o}, 32'd0);
  endtask

  initial begin
    arst_i = 1'b1;
    valid_i = 1'b0;
    address_i = '0;
    wdata_i = '0;
    wstrb_i = '0;
    wb_data_i = '0;
    wb_ack_i = 1'b0;
    wb_error_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    chk("rst_addr", wb_addr_o, 32'd0);
    arst_i = 1'b0;
    idle();

    // Directed read, ack on third strobe cycle
    txn(32'h40, 32'h0, 4'h0, 2, 0, 32'hDEADBEEF);
    idle();
    chk("lit_read_rdata", rdata_o, 32'hDEADBEEF);
    chk("lit_read_err", {31'd0, error_o}, 32'd0);

    // Directed write, same-cycle ack
    txn(32'h10, 32'h12345678, 4'h3, 0, 0, 32'hCAFEF00D);
    idle();
    chk("lit_write_rdata", rdata_o, 32'd0);

    // Error and ack together on a read
    txn(32'h44, 32'h0, 4'h0, 1, 2, 32'h55AA55AA);
    idle();
    chk("lit_err_rdata", rdata_o, 32'd0);
    chk("lit_err_flag", {31'd0, error_o}, 32'd1);

    // Silent slave: timeout, then a stray ack in IDLE
    txn(32'h80, 32'h0, 4'h0, 0, 3, 32'h0);
    idle();
    chk("lit_to_flag", {31'd0, error_o}, 32'd1);
    @(negedge clk);
    wb_ack_i = 1'b1;
    wb_data_i = 32'h11111111;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("stray_ack_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("stray_ack_ready", {31'd0, ready_o}, 32'd0);
    idle();

    // Back-to-back reads with random ack delay
    for (int i = 0; i < 8; i++)
      txn(32'h1000 + 32'(i * 4), $urandom, 4'h0,
          int'($urandom_range(0, 5)), 0, $urandom);
    idle();

    // Reset while BUSY
    @(negedge clk);
    valid_i = 1'b1;
    address_i = 32'h200;
    wstrb_i = 4'h0;
    @(negedge clk);
    chk("mid_busy_stb", {31'd0, wb_stb_o}, 32'd1);
    @(negedge clk);
    arst_i = 1'b1;
    #1;
    chk("mid_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    arst_i = 1'b0;
    idle();
    txn(32'h204, 32'h0, 4'h0, 1, 0, 32'h0BADF00D);
    idle();
    chk("post_rst_rdata", rdata_o, 32'h0BADF00D);

    // Random mixed traffic, occasionally past the timeout
    for (int i = 0; i < 24; i++) begin
      logic [3:0] st;
      st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      txn($urandom, $urandom, st, int'($urandom_range(0, 17)),
          int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    repeat (3) @(negedge clk);

    chk("ready_count", 32'(rdy_cnt), 32'(exp_cnt));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
